// File: rtl/timer_regs_mc.sv
// timer_regs_mc -- multi-channel down-counting timer with a memory-mapped
// register file and a registered, back-pressured read port.
//
// Parameters:
//   NCH  number of timer channels (1..8); channel c lives at byte base c*0x10
//   AW   byte-address width (>= 8); addresses with bits above [7:0] set are unmapped
//
// Ports:
//   clk, rst            single rising-edge clock, asynchronous active-high reset
//   wr_addr/wr_data/wr_strb/wr_en/wr_ready
//                       write channel; always accepted, completes in the wr_en cycle
//   rd_addr/rd_en/rd_ready/rd_data/rd_valid
//                       read channel; 1-cycle latency, data held while stalled
//   irq[NCH], irq_any   per-channel interrupt (IRQSTAT & IRQ_EN) and their OR
//
// Register map per channel: +0x0 CTRL {IRQ_EN,AUTORELOAD,EN}, +0x4 LOAD,
// +0x8 COUNT (read-only), +0xC IRQSTAT (bit0, write-1-to-clear).
// 0xF0 SUMMARY (read-only IRQSTAT of all channels).
//
// Build option: define TIMER_PRESCALE_EN to add the global PRESC register at
// 0xF4 and a shared prescaler issuing one tick every PRESC+1 cycles. Without
// it every cycle is a tick and 0xF4 behaves as an unmapped address.

module timer_regs_mc #(
  parameter int NCH = 4,
  parameter int AW  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [3:0]    wr_strb,
  input  logic          wr_en,
  output logic          wr_ready,
  input  logic [AW-1:0] rd_addr,
  input  logic          rd_en,
  input  logic          rd_ready,
  output logic [31:0]   rd_data,
  output logic          rd_valid,
  output logic [NCH-1:0] irq,
  output logic          irq_any
);

  localparam logic [31:0] BAD_DATA     = 32'hDEAD_BEEF;
  localparam logic [7:0]  ADDR_SUMMARY = 8'hF0;
  localparam logic [7:0]  ADDR_PRESC   = 8'hF4;
  localparam logic [1:0]  OFF_CTRL     = 2'd0;
  localparam logic [1:0]  OFF_LOAD     = 2'd1;
  localparam logic [1:0]  OFF_COUNT    = 2'd2;
  localparam logic [1:0]  OFF_STAT     = 2'd3;

  // Address is inside the 256-byte register page and word aligned.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ((a >> 8) == {AW{1'b0}}) && (a[1:0] == 2'b00);
  endfunction

  // Byte-enable merge of new write data into an existing word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  logic [NCH-1:0] en_q, en_d, ar_q, ar_d, ie_q, ie_d, irqstat_q, irqstat_d;
  logic [31:0]    load_q [NCH];
  logic [31:0]    load_d [NCH];
  logic [31:0]    count_q [NCH];
  logic [31:0]    count_d [NCH];
  logic [NCH-1:0] ctrl_wr_s, load_wr_s, stat_clr_s, en_rise_s, fire_s;
  logic           wr_ok_s;
  logic           tick_s;
  logic           rd_accept_s;
  logic [31:0]    rd_mux_s;
  logic [31:0]    rd_data_q, rd_data_d;
  logic           rd_valid_q, rd_valid_d;

  assign wr_ready = 1'b1;

`ifdef TIMER_PRESCALE_EN
  logic [31:0] presc_q, presc_d, psc_cnt_q, psc_cnt_d;
  logic        presc_wr_s;

  // Shared prescaler: tick on the cycle the counter reaches PRESC; any PRESC write restarts it.
  always_comb begin
    presc_wr_s = wr_en && addr_ok(wr_addr) && (wr_addr[7:0] == ADDR_PRESC);
    tick_s     = (psc_cnt_q == presc_q);
    if (presc_wr_s) begin
      presc_d   = merge_bytes(presc_q, wr_data, wr_strb);
      psc_cnt_d = 32'd0;
    end else if (tick_s) begin
      presc_d   = presc_q;
      psc_cnt_d = 32'd0;
    end else begin
      presc_d   = presc_q;
      psc_cnt_d = psc_cnt_q + 32'd1;
    end
  end

  // Prescaler state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= 32'd0;
      psc_cnt_q <= 32'd0;
    end else begin
      presc_q   <= presc_d;
      psc_cnt_q <= psc_cnt_d;
    end
  end
`else
  assign tick_s = 1'b1;
`endif

  // Per-channel write decode and hardware expiry events.
  always_comb begin
    wr_ok_s    = wr_en && addr_ok(wr_addr);
    ctrl_wr_s  = {NCH{1'b0}};
    load_wr_s  = {NCH{1'b0}};
    stat_clr_s = {NCH{1'b0}};
    en_rise_s  = {NCH{1'b0}};
    fire_s     = {NCH{1'b0}};
    for (int c = 0; c < NCH; c++) begin
      if (wr_ok_s && (wr_addr[7:4] == 4'(c))) begin
        ctrl_wr_s[c]  = (wr_addr[3:2] == OFF_CTRL) && wr_strb[0];
        load_wr_s[c]  = (wr_addr[3:2] == OFF_LOAD);
        stat_clr_s[c] = (wr_addr[3:2] == OFF_STAT) && wr_strb[0] && wr_data[0];
      end else begin
        ctrl_wr_s[c]  = 1'b0;
        load_wr_s[c]  = 1'b0;
        stat_clr_s[c] = 1'b0;
      end
      en_rise_s[c] = ctrl_wr_s[c] && wr_data[0] && !en_q[c];
      fire_s[c]    = tick_s && en_q[c] && (count_q[c] == 32'd0);
    end
  end

  // Next-state for CTRL, LOAD, COUNT and IRQSTAT of every channel.
  always_comb begin
    en_d      = en_q;
    ar_d      = ar_q;
    ie_d      = ie_q;
    irqstat_d = irqstat_q;
    for (int c = 0; c < NCH; c++) begin
      load_d[c]  = load_q[c];
      count_d[c] = count_q[c];

      // Software CTRL write overrides the hardware EN clear of a one-shot expiry.
      if (ctrl_wr_s[c]) begin
        en_d[c] = wr_data[0];
        ar_d[c] = wr_data[1];
        ie_d[c] = wr_data[2];
      end else if (fire_s[c] && !ar_q[c]) begin
        en_d[c] = 1'b0;
      end else begin
        en_d[c] = en_q[c];
      end

      if (load_wr_s[c]) begin
        load_d[c] = merge_bytes(load_q[c], wr_data, wr_strb);
      end else begin
        load_d[c] = load_q[c];
      end

      // Enable edge loads COUNT and suppresses the decrement in that cycle.
      if (en_rise_s[c]) begin
        count_d[c] = load_q[c];
      end else if (tick_s && en_q[c]) begin
        if (count_q[c] != 32'd0) begin
          count_d[c] = count_q[c] - 32'd1;
        end else if (ar_q[c]) begin
          count_d[c] = load_q[c];
        end else begin
          count_d[c] = 32'd0;
        end
      end else begin
        count_d[c] = count_q[c];
      end

      // Hardware set takes priority over a same-cycle write-1-to-clear.
      if (fire_s[c]) begin
        irqstat_d[c] = 1'b1;
      end else if (stat_clr_s[c]) begin
        irqstat_d[c] = 1'b0;
      end else begin
        irqstat_d[c] = irqstat_q[c];
      end
    end
  end

  // Channel register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q      <= {NCH{1'b0}};
      ar_q      <= {NCH{1'b0}};
      ie_q      <= {NCH{1'b0}};
      irqstat_q <= {NCH{1'b0}};
      for (int c = 0; c < NCH; c++) begin
        load_q[c]  <= 32'd0;
        count_q[c] <= 32'd0;
      end
    end else begin
      en_q      <= en_d;
      ar_q      <= ar_d;
      ie_q      <= ie_d;
      irqstat_q <= irqstat_d;
      for (int c = 0; c < NCH; c++) begin
        load_q[c]  <= load_d[c];
        count_q[c] <= count_d[c];
      end
    end
  end

  // Read address decode; anything not matched returns the unmapped pattern.
  always_comb begin
    rd_mux_s = BAD_DATA;
    if (addr_ok(rd_addr)) begin
      if (rd_addr[7:0] == ADDR_SUMMARY) begin
        rd_mux_s = {{(32-NCH){1'b0}}, irqstat_q};
`ifdef TIMER_PRESCALE_EN
      end else if (rd_addr[7:0] == ADDR_PRESC) begin
        rd_mux_s = presc_q;
`endif
      end else begin
        for (int c = 0; c < NCH; c++) begin
          if (rd_addr[7:4] == 4'(c)) begin
            case (rd_addr[3:2])
              OFF_CTRL:  rd_mux_s = {29'd0, ie_q[c], ar_q[c], en_q[c]};
              OFF_LOAD:  rd_mux_s = load_q[c];
              OFF_COUNT: rd_mux_s = count_q[c];
              OFF_STAT:  rd_mux_s = {31'd0, irqstat_q[c]};
              default:   rd_mux_s = BAD_DATA;
            endcase
          end else begin
            rd_mux_s = rd_mux_s;
          end
        end
      end
    end else begin
      rd_mux_s = BAD_DATA;
    end
  end

  // Read handshake: accept when the output slot is empty or being drained.
  always_comb begin
    rd_accept_s = rd_en && (!rd_valid_q || rd_ready);
    if (rd_accept_s) begin
      rd_valid_d = 1'b1;
      rd_data_d  = rd_mux_s;
    end else if (rd_ready) begin
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
    end else begin
      rd_valid_d = rd_valid_q;
      rd_data_d  = rd_data_q;
    end
  end

  // Read output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= 32'd0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign irq      = irqstat_q & ie_q;
  assign irq_any  = |(irqstat_q & ie_q);

endmodule

// File: tb/tb_timer_regs_mc.sv
module tb_timer_regs_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_en;
  logic        wr_ready;
  logic [7:0]  rd_addr;
  logic        rd_en;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [3:0]  irq;
  logic        irq_any;

  int n_chk  = 0;
  int n_fail = 0;

  timer_regs_mc #(.NCH(4), .AW(8)) dut (
    .clk(clk), .rst(rst),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb), .wr_en(wr_en),
    .wr_ready(wr_ready),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .irq(irq), .irq_any(irq_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic is_wr, input logic [7:0] addr,
                              input logic [31:0] data, input logic [3:0] strb,
                              input logic [31:0] exp, input string name);
    vec_t v;
    v.is_wr = is_wr; v.addr = addr; v.data = data;
    v.strb = strb; v.exp = exp; v.name = name;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    wr_addr = a; wr_data = d; wr_strb = s; wr_en = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic v);
    rd_addr = a; rd_en = 1'b1;
    @(posedge clk);
    #1;
    rd_en = 1'b0;
    d = rd_data;
    v = rd_valid;
  endtask

  initial begin
    logic [31:0] rdv;
    logic        vld;

    rst = 1'b1; wr_addr = 8'h00; wr_data = 32'd0; wr_strb = 4'h0; wr_en = 1'b0;
    rd_addr = 8'h00; rd_en = 1'b0; rd_ready = 1'b1;
    #12;
    chk("reset rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("reset rd_data", rd_data, 32'd0);
    chk("reset irq", {28'd0, irq}, 32'd0);
    chk("wr_ready", {31'd0, wr_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    step(1);

    // Register access table: byte strobes, read-only COUNT, unmapped space.
    tbl.push_back(mk(1'b0, 8'h04, 32'd0, 4'h0, 32'h0000_0000, "LOAD0 reset"));
    tbl.push_back(mk(1'b0, 8'h0C, 32'd0, 4'h0, 32'h0000_0000, "IRQSTAT0 reset"));
    tbl.push_back(mk(1'b1, 8'h04, 32'h0000_0000, 4'hF, 32'd0, ""));
    tbl.push_back(mk(1'b1, 8'h04, 32'hAABB_CCDD, 4'h3, 32'd0, ""));
    tbl.push_back(mk(1'b0, 8'h04, 32'd0, 4'h0, 32'h0000_CCDD, "LOAD0 strb 0011"));
    tbl.push_back(mk(1'b1, 8'h04, 32'h1122_3344, 4'hC, 32'd0, ""));
    tbl.push_back(mk(1'b0, 8'h04, 32'd0, 4'h0, 32'h1122_CCDD, "LOAD0 strb 1100"));
    tbl.push_back(mk(1'b0, 8'h40, 32'd0, 4'h0, 32'hDEAD_BEEF, "chan4 unmapped"));
    tbl.push_back(mk(1'b1, 8'h44, 32'h5555_5555, 4'hF, 32'd0, ""));
    tbl.push_back(mk(1'b0, 8'h44, 32'd0, 4'h0, 32'hDEAD_BEEF, "chan4 write ignored"));
    tbl.push_back(mk(1'b1, 8'h20, 32'hFFFF_FFF6, 4'hF, 32'd0, ""));
    tbl.push_back(mk(1'b0, 8'h20, 32'd0, 4'h0, 32'h0000_0006, "CTRL2 spare bits"));
    tbl.push_back(mk(1'b1, 8'h28, 32'h0000_1234, 4'hF, 32'd0, ""));
    tbl.push_back(mk(1'b0, 8'h28, 32'd0, 4'h0, 32'h0000_0000, "COUNT2 read-only"));
    tbl.push_back(mk(1'b0, 8'h30, 32'd0, 4'h0, 32'h0000_0000, "CTRL3 reset"));
    tbl.push_back(mk(1'b0, 8'h80, 32'd0, 4'h0, 32'hDEAD_BEEF, "0x80 unmapped"));
    tbl.push_back(mk(1'b0, 8'hF0, 32'd0, 4'h0, 32'h0000_0000, "SUMMARY idle"));
`ifdef TIMER_PRESCALE_EN
    tbl.push_back(mk(1'b0, 8'hF4, 32'd0, 4'h0, 32'h0000_0000, "PRESC reset"));
`else
    tbl.push_back(mk(1'b1, 8'hF4, 32'h0000_0007, 4'hF, 32'd0, ""));
    tbl.push_back(mk(1'b0, 8'hF4, 32'd0, 4'h0, 32'hDEAD_BEEF, "0xF4 absent"));
`endif

    foreach (tbl[i]) begin
      if (tbl[i].is_wr) begin
        do_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
      end else begin
        do_read(tbl[i].addr, rdv, vld);
        chk({tbl[i].name, " valid"}, {31'd0, vld}, 32'd1);
        chk(tbl[i].name, rdv, tbl[i].exp);
      end
    end

    // One-shot countdown on channel 0 with irq enabled.
    do_write(8'h04, 32'd5, 4'hF);
    do_write(8'h00, 32'h5, 4'hF);
    rd_addr = 8'h08; rd_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step(1);
      chk($sformatf("COUNT0 seq %0d", k), rd_data, 32'(5 - k));
      chk($sformatf("COUNT0 seq valid %0d", k), {31'd0, rd_valid}, 32'd1);
    end
    rd_en = 1'b0;
    chk("irq0 after expiry", {31'd0, irq[0]}, 32'd1);
    chk("irq_any after expiry", {31'd0, irq_any}, 32'd1);
    do_read(8'h00, rdv, vld);
    chk("CTRL0 EN cleared", rdv, 32'h0000_0004);
    step(3);
    do_read(8'h08, rdv, vld);
    chk("COUNT0 holds 0", rdv, 32'd0);
    do_read(8'hF0, rdv, vld);
    chk("SUMMARY ch0", rdv, 32'h0000_0001);
    do_write(8'h0C, 32'h0, 4'hF);
    chk("IRQSTAT0 write 0 no effect", {31'd0, irq[0]}, 32'd1);
    do_write(8'h0C, 32'h1, 4'hF);
    chk("IRQSTAT0 w1c", {31'd0, irq[0]}, 32'd0);

    // Auto-reload on channel 1: expiry every 3 ticks, set beats same-cycle clear.
    do_write(8'h14, 32'd2, 4'hF);
    do_write(8'h10, 32'h7, 4'hF);
    chk("irq1 B+0", {31'd0, irq[1]}, 32'd0);
    step(1); chk("irq1 B+1", {31'd0, irq[1]}, 32'd0);
    step(1); chk("irq1 B+2", {31'd0, irq[1]}, 32'd0);
    step(1); chk("irq1 B+3", {31'd0, irq[1]}, 32'd1);
    do_write(8'h1C, 32'h1, 4'h1);
    chk("irq1 B+4 cleared", {31'd0, irq[1]}, 32'd0);
    step(1); chk("irq1 B+5", {31'd0, irq[1]}, 32'd0);
    step(1); chk("irq1 B+6", {31'd0, irq[1]}, 32'd1);
    step(2);
    do_write(8'h1C, 32'h1, 4'h1);
    chk("irq1 set wins over w1c", {31'd0, irq[1]}, 32'd1);

    // Stalled read holds data; then back-to-back reads of a running counter.
    do_write(8'h04, 32'd100, 4'hF);
    do_write(8'h00, 32'h1, 4'hF);
    rd_addr = 8'h08; rd_en = 1'b1; rd_ready = 1'b0;
    step(1);
    chk("stall first valid", {31'd0, rd_valid}, 32'd1);
    chk("stall first data", rd_data, 32'd100);
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk($sformatf("stall valid %0d", k), {31'd0, rd_valid}, 32'd1);
      chk($sformatf("stall data %0d", k), rd_data, 32'd100);
    end
    rd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1);
      chk($sformatf("b2b data %0d", k), rd_data, 32'(96 - k));
      chk($sformatf("b2b valid %0d", k), {31'd0, rd_valid}, 32'd1);
    end
    rd_en = 1'b0;
    step(1);
    chk("rd_valid drops", {31'd0, rd_valid}, 32'd0);
    do_write(8'h00, 32'h0, 4'hF);

    // Asynchronous reset mid-count with a stalled read pending.
    do_write(8'h04, 32'd50, 4'hF);
    do_write(8'h00, 32'h5, 4'hF);
    rd_ready = 1'b0; rd_addr = 8'h08; rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    chk("pre-reset rd_valid", {31'd0, rd_valid}, 32'd1);
    chk("pre-reset irq_any", {31'd0, irq_any}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    chk("async rst rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("async rst rd_data", rd_data, 32'd0);
    chk("async rst irq", {28'd0, irq}, 32'd0);
    chk("async rst irq_any", {31'd0, irq_any}, 32'd0);
    step(2);
    rst = 1'b0;
    rd_ready = 1'b1;
    step(5);
    chk("post-reset rd_valid", {31'd0, rd_valid}, 32'd0);
    do_read(8'h08, rdv, vld);
    chk("post-reset COUNT0", rdv, 32'd0);
    do_read(8'h18, rdv, vld);
    chk("post-reset COUNT1", rdv, 32'd0);
    do_read(8'h00, rdv, vld);
    chk("post-reset CTRL0", rdv, 32'd0);
    chk("post-reset irq", {28'd0, irq}, 32'd0);

`ifdef TIMER_PRESCALE_EN
    // Prescaled one-shot: PRESC=3 gives a tick every 4 cycles, EN aligned to a tick.
    do_write(8'hF4, 32'd3, 4'hF);
    do_write(8'h04, 32'd2, 4'hF);
    step(2);
    do_write(8'h00, 32'h1, 4'hF);
    rd_addr = 8'h0C; rd_en = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      step(1);
      chk($sformatf("presc IRQSTAT0 E+%0d", k - 1), rd_data, (k >= 13) ? 32'd1 : 32'd0);
    end
    rd_en = 1'b0;
    do_read(8'hF4, rdv, vld);
    chk("PRESC readback", rdv, 32'd3);
`endif

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_regs_mc.md
TIMER_REGS_MC -- requirements
Module: timer_regs_mc

Interface
REQ-001 SHALL have parameter NCH, default 4, giving the number of timer channels (legal range 1..8).
REQ-002 SHALL have parameter AW, default 8, giving the byte-address width (minimum 8).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port wr_addr, input, AW bits: write byte address.
REQ-006 SHALL have port wr_data, input, 32 bits: write data.
REQ-007 SHALL have port wr_strb, input, 4 bits: byte enables for wr_data.
REQ-008 SHALL have port wr_en, input, 1 bit: write request.
REQ-009 SHALL have port wr_ready, output, 1 bit: write accept, tied to 1.
REQ-010 SHALL have port rd_addr, input, AW bits: read byte address.
REQ-011 SHALL have port rd_en, input, 1 bit: read request.
REQ-012 SHALL have port rd_ready, input, 1 bit: master accepts rd_data.
REQ-013 SHALL have port rd_data, output, 32 bits: registered read data.
REQ-014 SHALL have port rd_valid, output, 1 bit: rd_data is valid.
REQ-015 SHALL have port irq, output, NCH bits: per-channel interrupt.
REQ-016 SHALL have port irq_any, output, 1 bit: OR of irq.

Function
REQ-017 SHALL map channel c at base c*0x10 (see REQ-018..021); SUMMARY SHALL sit at 0xF0 (read-only, bits[NCH-1:0] = IRQSTAT bit0 of each channel).
REQ-018 CTRL at +0x0 SHALL be: bit0 EN, bit1 AUTORELOAD, bit2 IRQ_EN; other bits read 0.
REQ-019 LOAD at +0x4 SHALL be 32-bit read/write.
REQ-020 COUNT at +0x8 SHALL be read-only; writes ignored.
REQ-021 IRQSTAT at +0xC SHALL be bit0 only; writing 1 clears it, writing 0 has no effect.
REQ-022 Writes SHALL complete in the wr_en cycle; only bytes whose wr_strb bit is set are updated.
REQ-023 A CTRL write taking EN from 0 to 1 SHALL load COUNT with LOAD on the next edge, with no decrement in that cycle.
REQ-024 While EN=1 and COUNT!=0, COUNT SHALL decrement by 1 per tick; a tick is every clk cycle unless REQ-034 applies.
REQ-025 On a tick with EN=1 and COUNT==0:
- IRQSTAT SHALL be set;
- if AUTORELOAD=1, COUNT SHALL be reloaded from LOAD;
- if AUTORELOAD=0, EN SHALL be cleared and COUNT SHALL hold at 0.
REQ-026 If a hardware set and a W1C of IRQSTAT occur in the same cycle, set SHALL win.
REQ-027 If a software CTRL write coincides with a hardware EN clear, the software value SHALL win.
REQ-028 irq[c] SHALL equal IRQSTAT[c] AND IRQ_EN[c]; irq_any SHALL be the OR of irq.
REQ-029 A read SHALL be accepted when rd_en=1 and (rd_valid=0 or rd_ready=1).
- rd_data/rd_valid SHALL update on the next edge (1-cycle latency).
- rd_data SHALL be held stable while rd_valid=1 and rd_ready=0.
REQ-030 rd_valid SHALL drop after a cycle with rd_valid=1 and rd_ready=1 unless a new read is accepted in that same cycle.
REQ-031 Unmapped addresses, and channels >= NCH, SHALL read 0xDEADBEEF; writes to them are ignored.

Reset
REQ-032 On rst, all CTRL, LOAD, COUNT and IRQSTAT SHALL clear to 0, and rd_valid, rd_data, irq and irq_any SHALL be 0, immediately and regardless of clk.
REQ-033 A read pending when rst asserts SHALL be discarded, and counting SHALL restart only after software re-enables EN.

Configuration
REQ-034 With TIMER_PRESCALE_EN defined:
- a global read/write PRESC register exists at 0xF4 (reset 0);
- a shared prescaler issues one tick every PRESC+1 cycles;
- the prescaler restarts when PRESC is written.
Without TIMER_PRESCALE_EN, every cycle is a tick, 0xF4 reads 0xDEADBEEF, and writes to 0xF4 are ignored.

Verification
REQ-035 LOAD0=5, CTRL0=0x5 -> COUNT0 reads 5,4,3,2,1,0; IRQSTAT0 sets on the following tick; irq[0]=1; EN clears; COUNT holds 0.
REQ-036 LOAD1=2, CTRL1=0x7 -> irq[1] pulses every 3 ticks; writing IRQSTAT1=1 in the same cycle as a hardware set leaves the bit at 1.
REQ-037 Issue a read of 0x08 with rd_ready=0 for 3 cycles -> rd_valid=1 and rd_data stable throughout; back-to-back reads with rd_ready=1 -> one result per cycle.
REQ-038 Write LOAD0=0xAABBCCDD with wr_strb=4'b0011 after LOAD0=0 -> LOAD0 reads 0x0000CCDD; a read of 0x40 with NCH=4 -> 0xDEADBEEF.
REQ-039 Assert rst mid-count with a read pending -> all outputs 0 immediately; COUNT stays 0 after release.
REQ-040 With TIMER_PRESCALE_EN defined, PRESC=3, LOAD0=2, CTRL0=0x1 -> IRQSTAT0 sets 12 cycles after EN.
